// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with registered one-hot/binary grant and
//                optional hold-limit preemption of a long-running owner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int M        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int N        = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  output logic [M-1:0] grant,
  output logic [N-1:0] grant_idx,
  output logic         grant_valid,
  output logic         expire
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] c_hold_max = HW'(MAX_HOLD);
  localparam logic [HW-1:0] c_hold_one = HW'(1);
  localparam logic [M-1:0]  c_onehot0  = {{(M-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_last, w_last_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [M-1:0]    w_grant_nxt;
  logic [N-1:0]    w_idx_nxt;
  logic            w_expire_nxt;

  logic [N-1:0]    w_ptr;
  logic [N-1:0]    w_win_idx;
  logic            w_win_found;
  logic [M-1:0]    w_win_onehot;
  logic            w_owner_req;
  logic            w_others;
  logic            w_preempt;

  // While granted, the search always starts after the current owner.
  assign w_ptr        = (r_state == S_GRANT) ? grant_idx : r_last;
  assign w_win_onehot = c_onehot0 << w_win_idx;
  assign w_owner_req  = req[grant_idx];
  assign w_others     = |(req & ~grant);
  assign w_preempt    = (MAX_HOLD > 0) && (r_hold_cnt == c_hold_max) &&
                        w_owner_req && w_others;

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= M; k++) begin
      if (!w_win_found && req[(int'(w_ptr) + k) % M]) begin
        w_win_found = 1'b1;
        w_win_idx   = N'((int'(w_ptr) + k) % M);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_hold_nxt   = r_hold_cnt;
    w_grant_nxt  = grant;
    w_idx_nxt    = grant_idx;
    w_expire_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = w_win_onehot;
          w_idx_nxt   = w_win_idx;
          w_hold_nxt  = c_hold_one;
        end
      end
      S_GRANT: begin
        if (!w_owner_req) begin
          w_last_nxt = grant_idx;
          if (w_win_found) begin
            w_grant_nxt = w_win_onehot;
            w_idx_nxt   = w_win_idx;
            w_hold_nxt  = c_hold_one;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end else if (w_preempt) begin
          w_last_nxt   = grant_idx;
          w_grant_nxt  = w_win_onehot;
          w_idx_nxt    = w_win_idx;
          w_hold_nxt   = c_hold_one;
          w_expire_nxt = 1'b1;
        end else if ((MAX_HOLD > 0) && (r_hold_cnt != c_hold_max)) begin
          w_hold_nxt = r_hold_cnt + c_hold_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Pointer starts at M-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= N'(M - 1);
      r_hold_cnt  <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      expire      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_hold_cnt  <= w_hold_nxt;
      grant       <= w_grant_nxt;
      grant_idx   <= w_idx_nxt;
      grant_valid <= |w_grant_nxt;
      expire      <= w_expire_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Self-checking bench for rr_arbiter (M=4, MAX_HOLD=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

  localparam int M        = 4;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       expire;

  rr_arbiter #(.M(M), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .expire      (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_owner;
  int m_last;
  int m_hold;

  function automatic int search(input int p, input logic [3:0] r);
    for (int k = 1; k <= M; k++) begin
      if (r[(p + k) % M]) return (p + k) % M;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = M - 1;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    exp_t e;
    logic ex;
    int   w;
    ex = 1'b0;
    if (m_owner < 0) begin
      w = search(m_last, r);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
      end
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = search(m_owner, r);
      m_hold  = (m_owner >= 0) ? 1 : 0;
    end else if (m_hold == MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
      m_last  = m_owner;
      m_owner = search(m_owner, r);
      m_hold  = 1;
      ex      = 1'b1;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
    e.g   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.v   = (m_owner >= 0);
    e.e   = ex;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every pushed expectation is compared just after its edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if ({grant, grant_idx, grant_valid, expire} !== e)
        $display("FAIL scoreboard t=%0t: got g=%b idx=%0d v=%b e=%b, expected g=%b idx=%0d v=%b e=%b",
                 $time, grant, grant_idx, grant_valid, expire, e.g, e.idx, e.v, e.e);
      else
        n_pass++;
    end
  end

  task automatic drive(input logic [3:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, grant_idx, grant_valid, expire} !== 8'b0)
      $display("FAIL reset_release: got %b, expected 00000000", {grant, grant_idx, grant_valid, expire});
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      drive(4'b0000);
      @(posedge clk); #1;
      n_checks++;
      if ({grant, grant_idx, grant_valid, expire} !== 8'b0)
        $display("FAIL reset_idle c=%0d: got %b, expected 00000000", c, {grant, grant_idx, grant_valid, expire});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b1010);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1)
      $display("FAIL b2b_first: got g=%b idx=%0d v=%b, expected g=0010 idx=1 v=1", grant, grant_idx, grant_valid);
    else n_pass++;
    drive(4'b1000);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3 || grant_valid !== 1'b1)
      $display("FAIL b2b_handover: got g=%b idx=%0d v=%b, expected g=1000 idx=3 v=1", grant, grant_idx, grant_valid);
    else n_pass++;
  endtask

  task automatic test_rotation();
    int o;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(4'b1111);
      @(posedge clk); #1;
      o = (c / 4) % 4;
      n_checks++;
      if (grant !== (4'b0001 << o) || grant_idx !== 2'(o) ||
          expire !== ((c % 4 == 0) && (c > 0)))
        $display("FAIL rotation c=%0d: got g=%b idx=%0d e=%b, expected owner=%0d e=%b",
                 c, grant, grant_idx, expire, o, (c % 4 == 0) && (c > 0));
      else n_pass++;
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(4'b0100);
      @(posedge clk); #1;
      n_checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2 || expire !== 1'b0)
        $display("FAIL sole c=%0d: got g=%b idx=%0d e=%b, expected g=0100 idx=2 e=0", c, grant, grant_idx, expire);
      else n_pass++;
    end
  endtask

  task automatic test_release_idle();
    drive(4'b0000);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0)
      $display("FAIL release_idle: got g=%b idx=%0d v=%b, expected g=0000 idx=0 v=0", grant, grant_idx, grant_valid);
    else n_pass++;
    drive(4'b1001);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3)
      $display("FAIL release_regrant: got g=%b idx=%0d, expected g=1000 idx=3", grant, grant_idx);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(4'b0100);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0100)
      $display("FAIL areset_setup: got g=%b, expected g=0100", grant);
    else n_pass++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    sb_q.delete();
    model_reset();
    #1;
    n_checks++;
    if ({grant, grant_idx, grant_valid, expire} !== 8'b0)
      $display("FAIL areset_clear: got %b, expected 00000000", {grant, grant_idx, grant_valid, expire});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111);
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0)
      $display("FAIL areset_first: got g=%b idx=%0d, expected g=0001 idx=0", grant, grant_idx);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      drive(4'($urandom_range(0, 15)));
    end
    drive(4'b0000);
    @(posedge clk); #2;
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_back_to_back();
    test_rotation();
    test_sole_requester();
    test_release_idle();
    test_async_reset();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
